// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: op encodings, FSM states and small helpers shared by the HI/LO unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mul_div_unit_pkg;

  typedef logic [3:0] mc_t;

  // Decoder's one-hot mul_control encodings.
  localparam mc_t MC_MULT  = 4'b0001;
  localparam mc_t MC_MULTU = 4'b0010;
  localparam mc_t MC_DIV   = 4'b0100;
  localparam mc_t MC_DIVU  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // True when exactly one bit is set.
  function automatic logic onehot4(input mc_t v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Magnitude of v when treated as signed (sgn=1), otherwise v unchanged.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: issue/flush/register-write bundle between the execute stage and the HI/LO unit.
// Latency: n/a (wires only).
// Backpressure: busy from the unit; master must hold new HI/LO traffic while it is high.
// Ports: start, mul_control, op_a, op_b, cancel, hi_wen, lo_wen, wdata (master -> unit);
//   busy, done, hi, lo (unit -> master).
interface mul_div_unit_if;
  logic                   start;
  mul_div_unit_pkg::mc_t  mul_control;
  logic [31:0]            op_a;
  logic [31:0]            op_b;
  logic                   cancel;
  logic                   hi_wen;
  logic                   lo_wen;
  logic [31:0]            wdata;
  logic                   busy;
  logic                   done;
  logic [31:0]            hi;
  logic [31:0]            lo;

  modport master (
    output start, mul_control, op_a, op_b, cancel, hi_wen, lo_wen, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, mul_control, op_a, op_b, cancel, hi_wen, lo_wen, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit_div_iter.sv
// mul_div_unit_div_iter: restoring radix-2 unsigned divider core, one quotient bit per cycle.
// Latency: valid_o high ITER cycles after the start_i edge, for one cycle.
// Backpressure: none; abort_i drops the op, start_i reloads at any time.
// Ports: clk, rst (sync, active-high); start_i, abort_i; dividend_i, divisor_i in;
//   q_o, r_o, valid_o out. Divide by zero yields all-ones quotient and a meaningless remainder.
module mul_div_unit_div_iter #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] q_o,
  output logic [31:0] r_o,
  output logic        valid_o
);
  localparam logic [5:0] LAST = 6'(ITER);

  logic [31:0] rem_q, quo_q, dvs_q;
  logic [5:0]  cnt_q;
  logic        run_q;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;
  logic        last;
  logic        unused_diff_msb;

  // Partial remainder shifted left with the next dividend bit pulled in from the quotient register.
  assign shifted = {rem_q, quo_q[31]};
  assign fits    = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted - {1'b0, dvs_q};
  // When the trial subtraction fits, shifted < 2*divisor so the difference always fits in 32 bits.
  assign unused_diff_msb = diff[32];
  assign last    = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (abort_i) begin
      run_q <= 1'b0;
    end else if (run_q) begin
      if (last) begin
        run_q <= 1'b0;
      end else begin
        rem_q <= fits ? diff[31:0] : shifted[31:0];
        quo_q <= {quo_q[30:0], fits};
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

  assign q_o     = quo_q;
  assign r_o     = rem_q;
  assign valid_o = run_q & last;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: execute-stage HI/LO unit for MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes.
// Latency: multiply MUL_LAT busy cycles, divide DIV_ITER+1 busy cycles; done pulses the cycle after.
// Backpressure: busy high while an op is in flight; upstream holds further HI/LO traffic until it drops.
// Ports: clk, rst (sync, active-high); bus (slave): start/mul_control/op_a/op_b issue, cancel flush,
//   hi_wen/lo_wen/wdata register writes; busy/done/hi/lo status and architectural registers.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);
  localparam int              CNT_W    = 6;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       hi_q, lo_q;
  logic [63:0]       mul_pipe_q [MUL_LAT];
  logic              q_neg_q, r_neg_q, dvz_q;
  logic [31:0]       dvd_q;

  logic              accept, is_mul, is_signed;
  logic [63:0]       mul_a, mul_b, prod;
  logic [31:0]       quo, rem;
  logic              div_valid, div_start, div_abort;
  logic [31:0]       lo_div_d, hi_div_d;

  assign is_mul    = bus.mul_control[0] | bus.mul_control[1];
  assign is_signed = bus.mul_control[0] | bus.mul_control[2];
  // cancel in the issue cycle drops the start; malformed mul_control is silently ignored.
  assign accept    = (state_q == ST_IDLE) && bus.start && !bus.cancel && onehot4(bus.mul_control);

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then correct for both.
  assign mul_a = {{32{is_signed & bus.op_a[31]}}, bus.op_a};
  assign mul_b = {{32{is_signed & bus.op_b[31]}}, bus.op_b};
  assign prod  = mul_a * mul_b;

  assign div_start = accept & ~is_mul;
  assign div_abort = bus.cancel & (state_q == ST_DIV);

  mul_div_unit_div_iter #(.ITER(DIV_ITER)) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .abort_i    (div_abort),
    .dividend_i (mag32(bus.op_a, is_signed)),
    .divisor_i  (mag32(bus.op_b, is_signed)),
    .q_o        (quo),
    .r_o        (rem),
    .valid_o    (div_valid)
  );

  // Sign-fix cycle: the core's magnitudes become the architectural quotient/remainder.
  // The 0x80000000/-1 overflow needs no special case: the magnitude quotient 2^31 is already
  // the required LO and the signs agree, so no negation is applied.
  assign lo_div_d = dvz_q ? 32'hFFFF_FFFF : (q_neg_q ? (~quo + 32'd1) : quo);
  assign hi_div_d = dvz_q ? dvd_q         : (r_neg_q ? (~rem + 32'd1) : rem);

  // Product enters at the issue edge and shifts one stage per cycle; cnt_q picks the write edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      mul_pipe_q[0] <= prod;
    end
    for (int i = 1; i < MUL_LAT; i++) begin
      mul_pipe_q[i] <= mul_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dvz_q   <= 1'b0;
      dvd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // Register writes land even when an op issues in the same cycle; its result overwrites later.
          if (bus.hi_wen) hi_q <= bus.wdata;
          if (bus.lo_wen) lo_q <= bus.wdata;
          if (accept) begin
            state_q <= is_mul ? ST_MUL : ST_DIV;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            q_neg_q <= is_signed & (bus.op_a[31] ^ bus.op_b[31]);
            r_neg_q <= is_signed & bus.op_a[31];
            dvz_q   <= (bus.op_b == 32'd0);
            dvd_q   <= bus.op_a;
          end
        end
        ST_MUL: begin
          if (bus.cancel) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == MUL_LAST) begin
            hi_q    <= mul_pipe_q[MUL_LAT-1][63:32];
            lo_q    <= mul_pipe_q[MUL_LAT-1][31:0];
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DIV: begin
          if (bus.cancel) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (div_valid) begin
            hi_q    <= hi_div_d;
            lo_q    <= lo_div_d;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // MTHI/MTLO while busy are dropped by the datapath; this flags the upstream stall violation.
  always_ff @(posedge clk) begin
    if (!rst && busy_q) begin
      assert (!(bus.hi_wen || bus.lo_wen))
        else $warning("mul_div_unit: HI/LO write while busy was dropped");
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors against a cycle-count reference model of the HI/LO unit.
// Latency: n/a.
// Backpressure: n/a.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int MUL_LAT  = 2;
  localparam int DIV_BUSY = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_div_unit_if bus();

  mul_div_unit #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Architectural result of one op, computed with plain integer arithmetic.
  task automatic ref_result(input mc_t mc, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] h, output logic [31:0] l);
    longint      sp;
    logic [63:0] pv;
    int          sa, sb;
    h = 32'd0;
    l = 32'd0;
    sa = a;
    sb = b;
    case (mc)
      MC_MULT: begin
        sp = longint'(sa) * longint'(sb);
        pv = sp;
        h = pv[63:32];
        l = pv[31:0];
      end
      MC_MULTU: begin
        pv = {32'd0, a} * {32'd0, b};
        h = pv[63:32];
        l = pv[31:0];
      end
      MC_DIV: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF; h = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 32'd0;
        end else begin
          l = sa / sb;
          h = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF; h = a;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endtask

  // Reference model: remaining busy cycles plus the pending result.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;

  always @(posedge clk) begin : model
    logic nd;
    nd = 1'b0;
    if (rst) begin
      m_left = 0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
    end else if (m_left > 0) begin
      if (bus.cancel) begin
        m_left = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_hi = m_phi;
          m_lo = m_plo;
          nd   = 1'b1;
        end
      end
    end else begin
      if (bus.hi_wen) m_hi = bus.wdata;
      if (bus.lo_wen) m_lo = bus.wdata;
      if (bus.start && !bus.cancel && $countones(bus.mul_control) == 1) begin
        ref_result(bus.mul_control, bus.op_a, bus.op_b, m_phi, m_plo);
        m_left = (bus.mul_control inside {MC_MULT, MC_MULTU}) ? MUL_LAT : DIV_BUSY;
      end
    end
    m_done = nd;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", 32'(bus.busy), 32'(m_left > 0));
      check("cyc_done", 32'(bus.done), 32'(m_done));
      check("cyc_hi", bus.hi, m_hi);
      check("cyc_lo", bus.lo, m_lo);
    end
  end

  // All driver tasks start and end positioned at a falling edge.
  task automatic issue(input mc_t mc, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.mul_control = mc; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.mul_control = 4'd0;
  endtask

  task automatic wait_done(input string name, output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    for (int k = 0; k < 200; k++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) cycles++;
      @(negedge clk);
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic run_op(input string name, input mc_t mc, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    issue(mc, a, b);
    wait_done(name, cyc);
    check({name, "_busy_cycles"}, 32'(cyc), 32'(exp_busy));
    check({name, "_hi"}, bus.hi, exp_hi);
    check({name, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    int cyc;
    int dones;
    bus.start = 1'b0; bus.mul_control = 4'd0; bus.op_a = 32'd0; bus.op_b = 32'd0;
    bus.cancel = 1'b0; bus.hi_wen = 1'b0; bus.lo_wen = 1'b0; bus.wdata = 32'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back ops: each new issue lands in the previous op's done cycle.
    run_op("mult",     MC_MULT,  32'hFFFF_FFFF, 32'd2,         MUL_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu",    MC_MULTU, 32'hFFFF_FFFF, 32'd2,         MUL_LAT,  32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_nn",  MC_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, MUL_LAT,  32'h0000_0000, 32'h0000_000F);
    run_op("div_m7_2", MC_DIV,   32'hFFFF_FFF9, 32'd2,         DIV_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", MC_DIV,   32'd7,         32'hFFFF_FFFE, DIV_BUSY, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu",     MC_DIVU,  32'h8000_0000, 32'd3,         DIV_BUSY, 32'h0000_0002, 32'h2AAA_AAAA);
    run_op("div_by0",  MC_DIV,   32'd5,         32'd0,         DIV_BUSY, 32'h0000_0005, 32'hFFFF_FFFF);
    run_op("divu_by0", MC_DIVU,  32'hFFFF_FFF0, 32'd0,         DIV_BUSY, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("div_ovf",  MC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_BUSY, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_big", MC_DIVU,  32'hFFFF_FFFF, 32'h10,        DIV_BUSY, 32'h0000_000F, 32'h0FFF_FFFF);
    run_op("mult_dc",  MC_MULT,  32'd6,         32'd7,         MUL_LAT,  32'h0000_0000, 32'h0000_002A);

    // MTHI/MTLO together, then separately.
    @(negedge clk);
    bus.hi_wen = 1'b1; bus.lo_wen = 1'b1; bus.wdata = 32'h33;
    @(negedge clk);
    bus.hi_wen = 1'b0; bus.lo_wen = 1'b0;
    check("mt_both_hi", bus.hi, 32'h33);
    check("mt_both_lo", bus.lo, 32'h33);
    bus.hi_wen = 1'b1; bus.wdata = 32'h11;
    @(negedge clk);
    bus.hi_wen = 1'b0;
    check("mthi", bus.hi, 32'h11);
    bus.lo_wen = 1'b1; bus.wdata = 32'h22;
    @(negedge clk);
    bus.lo_wen = 1'b0;
    check("mtlo_lo", bus.lo, 32'h22);
    check("mtlo_hi", bus.hi, 32'h11);

    // Cancel a divide in busy cycle 10.
    issue(MC_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    check("cancel_pre_busy", 32'(bus.busy), 32'd1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", 32'(bus.busy), 32'd0);
    check("cancel_done", 32'(bus.done), 32'd0);
    check("cancel_hi", bus.hi, 32'h11);
    check("cancel_lo", bus.lo, 32'h22);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("cancel_no_done", 32'(dones), 32'd0);

    // Cancel with start in IDLE drops the start; cancel alone in IDLE does nothing.
    bus.cancel = 1'b1;
    issue(MC_MULT, 32'd3, 32'd3);
    bus.cancel = 1'b0;
    check("cancel_start_busy", 32'(bus.busy), 32'd0);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_idle_hi", bus.hi, 32'h11);

    // Malformed mul_control is ignored.
    issue(4'b0110, 32'd9, 32'd9);
    check("mc_0110_busy", 32'(bus.busy), 32'd0);
    issue(4'b0000, 32'd9, 32'd9);
    check("mc_0000_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("mc_bad_done", 32'(bus.done), 32'd0);

    // MTHI while busy is dropped; the divide result still lands.
    issue(MC_DIVU, 32'd100, 32'd7);
    bus.hi_wen = 1'b1; bus.wdata = 32'hDEAD;
    @(negedge clk);
    bus.hi_wen = 1'b0;
    check("busy_wr_hi", bus.hi, 32'h11);
    wait_done("busy_wr", cyc);
    check("busy_wr_res_hi", bus.hi, 32'd2);
    check("busy_wr_res_lo", bus.lo, 32'd14);

    // Start together with MTHI: the write lands now, the product overwrites it later.
    bus.hi_wen = 1'b1; bus.wdata = 32'h55;
    issue(MC_MULTU, 32'd3, 32'd4);
    bus.hi_wen = 1'b0;
    check("start_wr_hi", bus.hi, 32'h55);
    check("start_wr_busy", 32'(bus.busy), 32'd1);
    wait_done("start_wr", cyc);
    check("start_wr_res_hi", bus.hi, 32'd0);
    check("start_wr_res_lo", bus.lo, 32'd12);

    // Reset in busy cycle 5 of a divide.
    issue(MC_DIV, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    check("rst_mid_hi", bus.hi, 32'd0);
    check("rst_mid_lo", bus.lo, 32'd0);
    repeat (40) @(negedge clk);
    run_op("after_rst", MC_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'd0, 32'd1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
